uart_cmd_assembler: RTL and testbench
=====================================

// Module: uart_cmd_assembler
// PURPOSE
//  Parametrised successor of the ASCII UART command decoder. Consumes received UART
//  bytes, classifies hex digits and command letters, assembles {cmd, payload} words
//  of configurable width, and queues them in a small FIFO for the wishbone master.
//  Adds word-overflow/error detection, explicit terminators and downstream backpressure.
// PARAMETERS
//  DW          32  payload width in bits; multiple of 4, 8..64; NIB = DW/4 digits max
//  FIFO_DEPTH  4   output queue depth in words; power of 2, >= 2
// PORTS
//  i_clk       in   1       single clock; all logic on posedge
//  i_reset     in   1       synchronous, active-high reset
//  i_stb       in   1       one-cycle strobe: i_byte holds a received byte
//  i_byte      in   8       received byte; bit 7 ignored (7-bit ASCII)
//  i_busy      in   1       downstream cannot accept; word moves when o_stb && !i_busy
//  o_stb       out  1       head word valid
//  o_word      out  DW+2    {cmd[1:0], payload[DW-1:0]}; cmd 00=R 01=W 10=A 11=S
//  o_err       out  1       one-cycle pulse: malformed input detected
//  o_drop      out  1       one-cycle pulse: completed word lost, FIFO full
// BEHAVIOUR
//  Reset: o_stb=0, o_word=0, o_err=0, o_drop=0, FIFO empty, FSM=IDLE, payload=0.
//  Stage 1 (registered): byte classes: '0'-'9','a'-'f' -> DIGIT(nibble);
//   'R','W','A','S' -> CMD; 'E',CR(0x0D),LF(0x0A) -> TERM; space(0x20) -> SKIP;
//   anything else -> OTHER. Uppercase 'B'-'F' are OTHER (only lowercase hex).
//  Stage 2 FSM, acts one cycle after the strobe, only when stage-1 valid:
//   IDLE: CMD -> OPEN (latch cmd, payload=0, ndig=0); DIGIT -> o_err, stay;
//         TERM/SKIP/OTHER -> stay, no error.
//   OPEN: DIGIT, ndig<NIB -> payload={payload[DW-5:0],nib}, ndig++;
//         DIGIT, ndig==NIB -> o_err, -> BAD; SKIP -> stay;
//         TERM -> push word, -> IDLE; CMD -> push word, reopen with new cmd (OPEN);
//         OTHER -> o_err, discard, -> IDLE.
//   BAD:  DIGIT/SKIP -> stay; TERM -> discard, -> IDLE; CMD -> discard, -> OPEN new;
//         OTHER -> -> IDLE (no second o_err).
//  Payload right-justified, zero-extended; zero digits legal (e.g. "RE" -> R, 0).
//  Latency: byte strobed in cycle N -> push at end of N+1 -> o_stb=1 in N+2
//   when FIFO was empty. o_stb/o_word driven from FIFO head (first-word fall-through).
//  Back-to-back i_stb every cycle supported at full rate.
//  FIFO: push when full and no pop in same cycle -> word dropped, o_drop pulse,
//   contents unchanged. Push+pop same cycle when full -> both happen, no drop.
//   Pop only when o_stb && !i_busy; o_word stable while o_stb && i_busy.
//  o_err and o_drop may pulse in the same cycle; each is exactly 1 cycle wide.
//  i_reset mid-word or with FIFO occupied: open word and queued words discarded.
// TESTING
//  1 DW=32: "A1000E" "W00ff\n" "R " "E" -> 3 words: {10,0x1000},{01,0xff},{00,0x0};
//    first o_stb exactly 2 cycles after 'E' strobe.
//  2 "A123W4E" -> {10,0x123} then {01,0x4}; command letter acts as terminator.
//  3 DW=8: "W123E" -> o_err one cycle after '3' strobe, no word pushed; then "W12E"
//    -> {01,0x12}.
//  4 i_busy=1, FIFO_DEPTH=4, send 5 "R1E" words -> 4 queued, o_drop on 5th; drop
//    i_busy -> 4 words drain one per cycle, o_stb low after.
//  5 "5E" in IDLE -> o_err, no word; "W1xE" -> o_err on 'x', no word; "Wf" then
//    i_reset, then "E" -> no word, o_stb stays 0.
//  6 FIFO full, i_busy=0 while a word completes -> pop+push same cycle, no o_drop,
//    order preserved.

Source files
------------

// File: rtl/uart_cmd_if.sv
// Byte-in / word-out handshake bundle for the UART command assembler.
// The receiver side (bench or UART) uses the master modport and the
// assembler uses the slave modport.
interface uart_cmd_if #(
  parameter int DW = 32
);
  logic          i_stb;
  logic [7:0]    i_byte;
  logic          i_busy;
  logic          o_stb;
  logic [DW+1:0] o_word;
  logic          o_err;
  logic          o_drop;

  modport master (
    output i_stb, i_byte, i_busy,
    input  o_stb, o_word, o_err, o_drop
  );

  modport slave (
    input  i_stb, i_byte, i_busy,
    output o_stb, o_word, o_err, o_drop
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// UART ASCII command assembler.
// Stage 1 registers the class of each received byte. Stage 2 is an FSM that
// builds {cmd, payload} words from hex digits. A first-word-fall-through FIFO
// queues finished words for a downstream consumer that may apply backpressure.
module uart_cmd_assembler #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  uart_cmd_if.slave  bus
);
  localparam int NIB = DW / 4;
  localparam int NW  = $clog2(NIB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {CL_DIGIT, CL_CMD, CL_TERM, CL_SKIP, CL_OTHER} cls_t;
  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_BAD} state_t;

  // ---------------- stage 1: byte classification ----------------
  logic [6:0] ch;
  cls_t       cls_c;
  logic [3:0] nib_c;
  logic [1:0] cmd_c;

  assign ch = bus.i_byte[6:0];

  // Decode the 7-bit ASCII byte; only lowercase letters count as hex digits.
  always_comb begin
    cls_c = CL_OTHER;
    nib_c = 4'd0;
    cmd_c = 2'd0;
    if (ch >= 7'h30 && ch <= 7'h39) begin
      cls_c = CL_DIGIT;
      nib_c = 4'(ch - 7'h30);
    end else if (ch >= 7'h61 && ch <= 7'h66) begin
      cls_c = CL_DIGIT;
      nib_c = 4'(ch - 7'h57);
    end else begin
      case (ch)
        7'h52:               begin cls_c = CL_CMD; cmd_c = 2'd0; end
        7'h57:               begin cls_c = CL_CMD; cmd_c = 2'd1; end
        7'h41:               begin cls_c = CL_CMD; cmd_c = 2'd2; end
        7'h53:               begin cls_c = CL_CMD; cmd_c = 2'd3; end
        7'h45, 7'h0D, 7'h0A: cls_c = CL_TERM;
        7'h20:               cls_c = CL_SKIP;
        default:             cls_c = CL_OTHER;
      endcase
    end
  end

  logic       s1_valid;
  cls_t       s1_cls;
  logic [3:0] s1_nib;
  logic [1:0] s1_cmd;

  // Register the classified byte so the FSM acts one cycle after the strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_cls   <= CL_OTHER;
      s1_nib   <= 4'd0;
      s1_cmd   <= 2'd0;
    end else begin
      s1_valid <= bus.i_stb;
      s1_cls   <= cls_c;
      s1_nib   <= nib_c;
      s1_cmd   <= cmd_c;
    end
  end

  // ---------------- stage 2: word assembly FSM ----------------
  state_t        state_r, state_s;
  logic [1:0]    cmd_r, cmd_s;
  logic [DW-1:0] payload_r, payload_s;
  logic [NW-1:0] ndig_r, ndig_s;
  logic          push_s;
  logic          err_s;

  // Hold FSM state, latched command, payload and digit count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r   <= ST_IDLE;
      cmd_r     <= 2'd0;
      payload_r <= '0;
      ndig_r    <= '0;
    end else begin
      state_r   <= state_s;
      cmd_r     <= cmd_s;
      payload_r <= payload_s;
      ndig_r    <= ndig_s;
    end
  end

  // Next state, push request and error pulse; a command letter both closes
  // the open word and starts the next one.
  always_comb begin
    state_s   = state_r;
    cmd_s     = cmd_r;
    payload_s = payload_r;
    ndig_s    = ndig_r;
    push_s    = 1'b0;
    err_s     = 1'b0;
    if (s1_valid && !i_reset) begin
      case (state_r)
        ST_IDLE: begin
          if (s1_cls == CL_CMD) begin
            state_s   = ST_OPEN;
            cmd_s     = s1_cmd;
            payload_s = '0;
            ndig_s    = '0;
          end else if (s1_cls == CL_DIGIT) begin
            err_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_OPEN: begin
          case (s1_cls)
            CL_DIGIT: begin
              if (ndig_r < NW'(NIB)) begin
                payload_s = {payload_r[DW-5:0], s1_nib};
                ndig_s    = ndig_r + 1'b1;
              end else begin
                err_s   = 1'b1;
                state_s = ST_BAD;
              end
            end
            CL_TERM: begin
              push_s  = 1'b1;
              state_s = ST_IDLE;
            end
            CL_CMD: begin
              push_s    = 1'b1;
              cmd_s     = s1_cmd;
              payload_s = '0;
              ndig_s    = '0;
            end
            CL_SKIP:  state_s = ST_OPEN;
            default: begin
              err_s   = 1'b1;
              state_s = ST_IDLE;
            end
          endcase
        end
        ST_BAD: begin
          case (s1_cls)
            CL_TERM:  state_s = ST_IDLE;
            CL_OTHER: state_s = ST_IDLE;
            CL_CMD: begin
              state_s   = ST_OPEN;
              cmd_s     = s1_cmd;
              payload_s = '0;
              ndig_s    = '0;
            end
            default:  state_s = ST_BAD;
          endcase
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // ---------------- output FIFO (first-word fall-through) ----------------
  logic [DW+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s, pop_s, wr_en_s;

  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign pop_s   = bus.o_stb && !bus.i_busy;
  assign wr_en_s = push_s && (!full_s || pop_s);

  assign bus.o_stb  = (count_r != '0);
  assign bus.o_word = bus.o_stb ? mem[rd_ptr_r] : '0;
  assign bus.o_err  = err_s;
  assign bus.o_drop = push_s && full_s && !pop_s;

  // Store the completed word; storage needs no reset since count gates o_word.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= {cmd_r, payload_r};
    end
  end

  // Advance pointers and occupancy; push and pop may coincide when full.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (pop_s)   rd_ptr_r <= rd_ptr_r + 1'b1;
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench: two assemblers (DW=32 and DW=8) share one byte stream.
// A string-based reference model predicts every output each cycle; a table of
// directed strings and a few hand-written sequences check the corner cases.
module tb_uart_cmd_assembler;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_if #(.DW(32)) ifa ();
  uart_cmd_if #(.DW(8))  ifb ();

  uart_cmd_assembler #(.DW(32), .FIFO_DEPTH(DEPTH)) dut_a (.i_clk(clk), .i_reset(rst), .bus(ifa));
  uart_cmd_assembler #(.DW(8),  .FIFO_DEPTH(DEPTH)) dut_b (.i_clk(clk), .i_reset(rst), .bus(ifb));

  int tests = 0;
  int fails = 0;

  // reference model state, index 0 = DW32 instance, 1 = DW8 instance
  int          dwm [2] = '{32, 8};
  int          mode[2];            // 0 idle, 1 word open, 2 overflowed
  int          mcmd[2];
  string       dig [2];            // hex digits of the open word
  logic [33:0] fq  [2][0:7];
  int          fn  [2];
  logic        pend_v = 1'b0;
  logic [7:0]  pend_b = 8'h00;

  // observations
  logic [33:0] cap_a[$], cap_b[$];
  int err_a, err_b, drop_a, drop_b, stb_a;

  function automatic int cls_of(input logic [7:0] b);
    logic [7:0] c;
    c = b & 8'h7f;
    if ((c >= "0" && c <= "9") || (c >= "a" && c <= "f")) return 0;
    if (c == "R" || c == "W" || c == "A" || c == "S") return 1;
    if (c == "E" || c == 8'h0d || c == 8'h0a) return 2;
    if (c == " ") return 3;
    return 4;
  endfunction

  function automatic int nib_of(input logic [7:0] b);
    logic [7:0] c;
    c = b & 8'h7f;
    return (c <= "9") ? int'(c) - 48 : int'(c) - 87;
  endfunction

  function automatic int cmd_of(input logic [7:0] b);
    logic [7:0] c;
    c = b & 8'h7f;
    return (c == "R") ? 0 : (c == "W") ? 1 : (c == "A") ? 2 : 3;
  endfunction

  function automatic logic [33:0] word_of(input int i);
    longint unsigned v;
    v = 0;
    for (int j = 0; j < dig[i].len(); j++) v = v * 16 + longint'(nib_of(dig[i][j]));
    return (34'(mcmd[i]) << dwm[i]) | 34'(v);
  endfunction

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model reaction of instance i to a byte: error pulse and pushed word
  task automatic model_byte(input int i, input logic [7:0] b, output logic ee,
                            output logic push, output logic [33:0] pw);
    int c;
    c = cls_of(b);
    ee = 1'b0; push = 1'b0; pw = '0;
    if (mode[i] == 1 && (c == 1 || c == 2)) begin
      push = 1'b1;
      pw = word_of(i);
    end
    if (c == 1) begin
      mode[i] = 1; mcmd[i] = cmd_of(b); dig[i] = "";
    end else if (mode[i] == 0) begin
      ee = (c == 0);
    end else if (mode[i] == 1) begin
      if (c == 0) begin
        if (dig[i].len() < dwm[i] / 4) dig[i] = $sformatf("%s%c", dig[i], b & 8'h7f);
        else begin ee = 1'b1; mode[i] = 2; end
      end else if (c == 2) mode[i] = 0;
      else if (c == 4) begin ee = 1'b1; mode[i] = 0; end
    end else begin
      if (c == 2 || c == 4) mode[i] = 0;
    end
  endtask

  // one clock cycle: drive inputs, compare both instances against the model
  task automatic step(input logic stb, input logic [7:0] b, input logic busy, input logic r);
    logic ee, push, es, ed, pop, as_, ae, ad;
    logic [33:0] pw, ew, aw;
    string nm;
    @(posedge clk);
    #1;
    ifa.i_stb = stb; ifa.i_byte = b; ifa.i_busy = busy;
    ifb.i_stb = stb; ifb.i_byte = b; ifb.i_busy = busy;
    rst = r;
    #1;
    for (int i = 0; i < 2; i++) begin
      ee = 1'b0; push = 1'b0; pw = '0;
      if (pend_v && !r) model_byte(i, pend_b, ee, push, pw);
      es  = (fn[i] > 0);
      ew  = es ? fq[i][0] : '0;
      pop = es && !busy;
      ed  = push && (fn[i] == DEPTH) && !pop;
      if (i == 0) begin
        as_ = ifa.o_stb; aw = 34'(ifa.o_word); ae = ifa.o_err; ad = ifa.o_drop;
      end else begin
        as_ = ifb.o_stb; aw = 34'(ifb.o_word); ae = ifb.o_err; ad = ifb.o_drop;
      end
      nm = (i == 0) ? "dw32" : "dw8";
      chk({nm, " o_stb"},  34'(as_), 34'(es));
      chk({nm, " o_word"}, aw, ew);
      chk({nm, " o_err"},  34'(ae), 34'(ee));
      chk({nm, " o_drop"}, 34'(ad), 34'(ed));
      if (r) begin
        fn[i] = 0; mode[i] = 0; mcmd[i] = 0; dig[i] = "";
      end else begin
        if (pop) begin
          for (int j = 0; j < 7; j++) fq[i][j] = fq[i][j+1];
          fn[i]--;
        end
        if (push && fn[i] < DEPTH) begin
          fq[i][fn[i]] = pw;
          fn[i]++;
        end
      end
    end
    if (!r) begin
      if (ifa.o_stb && !busy) cap_a.push_back(34'(ifa.o_word));
      if (ifb.o_stb && !busy) cap_b.push_back(34'(ifb.o_word));
      err_a += int'(ifa.o_err);  err_b += int'(ifb.o_err);
      drop_a += int'(ifa.o_drop); drop_b += int'(ifb.o_drop);
      stb_a += int'(ifa.o_stb);
    end
    pend_v = stb && !r;
    pend_b = b;
  endtask

  task automatic send(input string s, input logic busy);
    for (int j = 0; j < s.len(); j++) step(1'b1, s[j], busy, 1'b0);
  endtask

  task automatic idle(input int n, input logic busy);
    for (int j = 0; j < n; j++) step(1'b0, 8'h00, busy, 1'b0);
  endtask

  task automatic clear_obs();
    cap_a.delete(); cap_b.delete();
    err_a = 0; err_b = 0; drop_a = 0; drop_b = 0; stb_a = 0;
  endtask

  typedef struct {
    string       txt;
    int          nwa;
    logic [33:0] wa[3];
    int          erra;
    int          nwb;
    logic [33:0] wb0;
    int          errb;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [7:0] alpha_b;
    string      alpha;
    ifa.i_stb = 1'b0; ifa.i_byte = 8'h00; ifa.i_busy = 1'b0;
    ifb.i_stb = 1'b0; ifb.i_byte = 8'h00; ifb.i_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin mode[i] = 0; mcmd[i] = 0; dig[i] = ""; fn[i] = 0; end

    vt[0] = '{"A1000EW00ff\nR E", 3, '{{2'b10, 32'h1000}, {2'b01, 32'hff}, {2'b00, 32'h0}}, 0,
              1, {26'h0, 2'b00, 8'h00}, 2};
    vt[1] = '{"A123W4E", 2, '{{2'b10, 32'h123}, {2'b01, 32'h4}, 34'h0}, 0,
              1, {26'h0, 2'b01, 8'h04}, 1};
    vt[2] = '{"W123E", 1, '{{2'b01, 32'h123}, 34'h0, 34'h0}, 0, 0, 34'h0, 1};
    vt[3] = '{"W12E", 1, '{{2'b01, 32'h12}, 34'h0, 34'h0}, 0, 1, {26'h0, 2'b01, 8'h12}, 0};
    vt[4] = '{"5E", 0, '{34'h0, 34'h0, 34'h0}, 1, 0, 34'h0, 1};
    vt[5] = '{"W1xE", 0, '{34'h0, 34'h0, 34'h0}, 1, 0, 34'h0, 1};
    vt[6] = '{"S123456789E", 0, '{34'h0, 34'h0, 34'h0}, 1, 0, 34'h0, 1};
    vt[7] = '{"SabcdefE", 1, '{{2'b11, 32'habcdef}, 34'h0, 34'h0}, 0, 0, 34'h0, 1};
    vt[8] = '{"BE", 0, '{34'h0, 34'h0, 34'h0}, 0, 0, 34'h0, 0};
    vt[9] = '{"R \267 E", 1, '{{2'b00, 32'h7}, 34'h0, 34'h0}, 0, 1, {26'h0, 2'b00, 8'h07}, 0};

    // reset state
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset o_stb", 34'(ifa.o_stb), 34'h0);
    chk("reset o_word", 34'(ifa.o_word), 34'h0);
    chk("reset o_err", 34'(ifa.o_err), 34'h0);
    chk("reset o_drop", 34'(ifa.o_drop), 34'h0);

    // table-driven directed strings, no backpressure
    for (int v = 0; v < 10; v++) begin
      clear_obs();
      send(vt[v].txt, 1'b0);
      idle(6, 1'b0);
      chk($sformatf("vec%0d dw32 words", v), 34'(cap_a.size()), 34'(vt[v].nwa));
      for (int k = 0; k < vt[v].nwa && k < cap_a.size(); k++)
        chk($sformatf("vec%0d dw32 word%0d", v, k), cap_a[k], vt[v].wa[k]);
      chk($sformatf("vec%0d dw32 errs", v), 34'(err_a), 34'(vt[v].erra));
      chk($sformatf("vec%0d dw8 words", v), 34'(cap_b.size()), 34'(vt[v].nwb));
      if (vt[v].nwb > 0 && cap_b.size() > 0)
        chk($sformatf("vec%0d dw8 word0", v), cap_b[0], vt[v].wb0);
      chk($sformatf("vec%0d dw8 errs", v), 34'(err_b), 34'(vt[v].errb));
    end

    // latency: first o_stb exactly two cycles after the terminator strobe
    clear_obs();
    send("R5E", 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("latency N+1 o_stb", 34'(ifa.o_stb), 34'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("latency N+2 o_stb", 34'(ifa.o_stb), 34'h1);
    chk("latency N+2 o_word", 34'(ifa.o_word), {2'b00, 32'h5});
    idle(3, 1'b0);

    // backpressure: five words into a four-deep queue, then drain
    clear_obs();
    for (int k = 0; k < 5; k++) send("R1E", 1'b1);
    idle(3, 1'b1);
    chk("full drop count", 34'(drop_a), 34'h1);
    chk("full o_word held", 34'(ifa.o_word), {2'b00, 32'h1});
    stb_a = 0;
    idle(8, 1'b0);
    chk("drain word count", 34'(cap_a.size()), 34'h4);
    chk("drain stb cycles", 34'(stb_a), 34'h4);
    chk("drain o_stb low", 34'(ifa.o_stb), 34'h0);

    // full queue, push and pop in the same cycle
    clear_obs();
    send("R1ER2ER3ER4E", 1'b1);
    idle(2, 1'b1);
    send("R5E", 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("push+pop no drop", 34'(drop_a), 34'h0);
    idle(6, 1'b0);
    chk("push+pop count", 34'(cap_a.size()), 34'h5);
    for (int k = 0; k < 5 && k < cap_a.size(); k++)
      chk($sformatf("push+pop order%0d", k), cap_a[k], {2'b00, 32'(k + 1)});

    // reset discards an open word
    clear_obs();
    send("Wf", 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send("E", 1'b0);
    idle(4, 1'b0);
    chk("reset mid-word stb", 34'(stb_a), 34'h0);

    // reset discards queued words
    clear_obs();
    send("R1ER2E", 1'b1);
    idle(2, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    idle(1, 1'b0);
    chk("reset flush o_stb", 34'(ifa.o_stb), 34'h0);

    // randomized stream against the reference model
    alpha = "0123456789abcdefRWAS E\r\nxBF";
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) alpha_b = 8'($urandom_range(0, 255));
      else alpha_b = alpha[$urandom_range(0, alpha.len() - 1)];
      step(($urandom_range(0, 3) != 0), alpha_b, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 399) == 0));
    end
    idle(10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
